key_page_ctrl: RTL and testbench
================================

KEY_PAGE_CTRL -- requirements
Module: key_page_ctrl

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL provide parameter DEB_CYCLES, default 50000: vga_clk cycles between debounce samples (legal range 2..65535).
REQ-003 SHALL provide parameter NUM_PAGES, default 3: number of selectable pages (legal range 2..4).
REQ-004 SHALL provide parameter PAGE_KEY, default 0: index of the key that advances the page.
REQ-005 SHALL provide port vga_clk, input, 1 bit: pixel clock; all state is clocked on its rising edge.
REQ-006 SHALL provide port vga_rst, input, 1 bit: asynchronous reset, active-low.
REQ-007 SHALL provide port btn_raw, input, 16 bits: matrix-key scanner output; 1 means pressed; asynchronous to vga_clk and may bounce.
REQ-008 SHALL provide port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blanking.
REQ-009 SHALL provide port btn_level, output, 16 bits: debounced key levels.
REQ-010 SHALL provide port btn_press, output, 16 bits: one-cycle rising-edge pulse per debounced key.
REQ-011 SHALL provide port page_btns, output, 16 bits: debounced levels forwarded to the active page.
REQ-012 SHALL provide port page_status, output, 2 bits: active page index, 0..NUM_PAGES-1.
REQ-013 SHALL provide port switching, output, 1 bit: 1 while a page change is pending.

Function
REQ-014 SHALL pass btn_raw through a two-flop synchronizer before any other use.
REQ-015 SHALL run a shared prescaler that counts 0..DEB_CYCLES-1 and wraps to 0, and SHALL assert an internal tick in the cycle where the count equals DEB_CYCLES-1.
REQ-016 SHALL keep, per key, a 3-sample history and SHALL shift the synchronized bit into it on each tick.
REQ-017 SHALL set a key's btn_level to 1 on the tick where the history holds 3 ones, SHALL set it to 0 on the tick where the history holds 3 zeros, and SHALL otherwise hold its value.
REQ-018 SHALL assert btn_press[i] for exactly one cycle, in the cycle after btn_level[i] goes 0->1; a level going 1->0 SHALL produce no pulse.
REQ-019 SHALL implement a two-state FSM, IDLE and PENDING.
REQ-020 In IDLE, a btn_press[PAGE_KEY] pulse SHALL load target = page_status+1, wrap target to 0 when page_status = NUM_PAGES-1, and enter PENDING.
REQ-021 In PENDING, frame_start SHALL load page_status <= target and return the FSM to IDLE on the same edge.
REQ-022 In PENDING, further PAGE_KEY presses SHALL be ignored; they SHALL NOT queue or advance the page twice.
REQ-023 When a press arrives in IDLE in the same cycle as frame_start, the FSM SHALL enter PENDING, and the switch SHALL occur at the next frame_start, not the current one.
REQ-024 switching SHALL equal 1 exactly while the FSM is in PENDING.
REQ-025 page_btns SHALL equal btn_level with bit PAGE_KEY forced to 0 in IDLE, and SHALL be all zeros in PENDING.
REQ-026 page_status SHALL change only on a frame_start edge, so the displayed page never changes mid-frame.

Reset
REQ-027 While vga_rst = 0, the block SHALL immediately clear btn_level, btn_press, page_btns, page_status and switching to 0, clear the prescaler, histories and synchronizers to 0, and set the FSM to IDLE.
REQ-028 Reset asserted while in PENDING SHALL discard the pending switch; page_status SHALL be 0 after release.
REQ-029 After vga_rst is released, the first tick SHALL occur DEB_CYCLES cycles later.

Verification (DEB_CYCLES=4, NUM_PAGES=3, PAGE_KEY=0)
REQ-030 Debounce: btn_raw[5]=1 held -> btn_level[5]=1 on the third tick that samples 1; btn_press[5] pulses for 1 cycle on the next cycle; page_btns[5]=1.
REQ-031 Bounce rejection: btn_raw[5] toggles every 4 cycles for 40 cycles -> btn_level[5] stays 0 and btn_press stays 0.
REQ-032 Page advance: press key 0, frame_start 100 cycles later -> switching=1 and page_btns=0 during the wait; page_status goes 0->1 on the frame_start edge; switching=0 after it.
REQ-033 Wrap and ignore: three accepted advances -> page_status sequence 1,2,0; a second key-0 press while PENDING -> only a single increment.
REQ-034 Simultaneous events: press pulse coincides with frame_start -> page_status unchanged on that edge, and updates on the following frame_start.
REQ-035 Reset mid-PENDING: pull vga_rst low while PENDING -> all outputs 0 asynchronously; after release with no press and with frame_start pulses -> page_status remains 0.

Source files
------------

// File: rtl/key_page_ctrl_if.sv
// Bus between the key scanner / video timing side and the page controller.
// The master drives raw keys and frame timing; the controller (slave) returns debounced keys and page state.
interface key_page_ctrl_if;
    logic [15:0] btn_raw;
    logic        frame_start;
    logic [15:0] btn_level;
    logic [15:0] btn_press;
    logic [15:0] page_btns;
    logic [1:0]  page_status;
    logic        switching;

    modport master (
        output btn_raw,
        output frame_start,
        input  btn_level,
        input  btn_press,
        input  page_btns,
        input  page_status,
        input  switching
    );

    modport slave (
        input  btn_raw,
        input  frame_start,
        output btn_level,
        output btn_press,
        output page_btns,
        output page_status,
        output switching
    );
endinterface

// File: rtl/key_page_ctrl.sv
// Debounces a 16-key matrix and advances a display page on a dedicated key.
// The page itself only changes at the start of vertical blanking, so it never tears mid-frame.
module key_page_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int NUM_PAGES  = 3,
    parameter int PAGE_KEY   = 0
) (
    input  logic             vga_clk,
    input  logic             vga_rst,
    key_page_ctrl_if.slave   bus
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    localparam logic [15:0] DEB_LAST  = 16'(DEB_CYCLES - 1);
    localparam logic [1:0]  LAST_PAGE = 2'(NUM_PAGES - 1);
    localparam logic [15:0] PAGE_MASK = 16'(1) << PAGE_KEY;

    logic [15:0]      sync1_q, sync1_d;
    logic [15:0]      sync2_q, sync2_d;
    logic [15:0]      cnt_q, cnt_d;
    logic [15:0][2:0] hist_q, hist_d;
    logic [15:0]      level_q, level_d;
    logic [15:0]      level_dly_q, level_dly_d;
    logic [15:0]      press_q, press_d;
    logic [15:0]      page_btns_q, page_btns_d;
    logic [1:0]       page_q, page_d;
    logic [1:0]       target_q, target_d;
    logic             switching_q, switching_d;
    state_t           state_q, state_d;
    logic             tick;

    always_comb begin
        sync1_d = bus.btn_raw;
        sync2_d = sync1_q;

        tick  = (cnt_q == DEB_LAST);
        cnt_d = tick ? 16'd0 : cnt_q + 16'd1;

        // Level only flips once three consecutive samples agree; mixed history holds it.
        hist_d  = hist_q;
        level_d = level_q;
        if (tick) begin
            for (int i = 0; i < 16; i++) begin
                hist_d[i] = {hist_q[i][1:0], sync2_q[i]};
                if (hist_d[i] == 3'b111) begin
                    level_d[i] = 1'b1;
                end else if (hist_d[i] == 3'b000) begin
                    level_d[i] = 1'b0;
                end
            end
        end

        level_dly_d = level_q;
        press_d     = level_q & ~level_dly_q;

        state_d  = state_q;
        target_d = target_q;
        page_d   = page_q;
        case (state_q)
            IDLE: begin
                // A frame_start in the same cycle is deliberately ignored here.
                if (press_q[PAGE_KEY]) begin
                    target_d = (page_q == LAST_PAGE) ? 2'd0 : page_q + 2'd1;
                    state_d  = PENDING;
                end
            end
            PENDING: begin
                if (bus.frame_start) begin
                    page_d  = target_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        switching_d = (state_d == PENDING);
        page_btns_d = switching_d ? 16'd0 : (level_d & ~PAGE_MASK);
    end

    always_ff @(posedge vga_clk or negedge vga_rst) begin
        if (!vga_rst) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cnt_q       <= '0;
            hist_q      <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            page_btns_q <= '0;
            page_q      <= '0;
            target_q    <= '0;
            switching_q <= 1'b0;
            state_q     <= IDLE;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            hist_q      <= hist_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            press_q     <= press_d;
            page_btns_q <= page_btns_d;
            page_q      <= page_d;
            target_q    <= target_d;
            switching_q <= switching_d;
            state_q     <= state_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.page_btns   = page_btns_q;
    assign bus.page_status = page_q;
    assign bus.switching   = switching_q;

endmodule

// File: tb/tb_key_page_ctrl.sv
// Self-checking bench for key_page_ctrl: directed scenarios plus random key traffic,
// compared every cycle against a behavioural model built from run-length debounce rules.
module tb_key_page_ctrl;

    localparam int DEB = 4;
    localparam int NP  = 3;
    localparam int PK  = 0;

    logic vga_clk = 1'b0;
    logic vga_rst = 1'b1;

    always #5 vga_clk = ~vga_clk;

    key_page_ctrl_if kp_if ();

    key_page_ctrl #(
        .DEB_CYCLES(DEB),
        .NUM_PAGES (NP),
        .PAGE_KEY  (PK)
    ) dut (
        .vga_clk(vga_clk),
        .vga_rst(vga_rst),
        .bus    (kp_if)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model state: consecutive-sample run lengths instead of shift histories.
    int          run1 [16];
    int          run0 [16];
    logic [15:0] m_level, m_level_prev, m_press;
    int          m_page, m_target;
    bit          m_pending;
    int          edge_n;
    logic [15:0] raw_hist[$];

    int press_cnt5;
    int level5_seen;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            run1[i] = 0;
            run0[i] = 3;
        end
        m_level      = '0;
        m_level_prev = '0;
        m_press      = '0;
        m_page       = 0;
        m_target     = 0;
        m_pending    = 1'b0;
        edge_n       = 0;
        raw_hist.delete();
    endtask

    task automatic model_edge(input logic [15:0] raw, input logic fs);
        logic [15:0] synced;
        logic [15:0] new_level;
        logic [15:0] new_press;
        synced = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size()-2] : 16'd0;
        raw_hist.push_back(raw);
        if (raw_hist.size() > 3) void'(raw_hist.pop_front());

        new_level = m_level;
        if ((edge_n % DEB) == DEB - 1) begin
            for (int i = 0; i < 16; i++) begin
                if (synced[i]) begin
                    run1[i]++;
                    run0[i] = 0;
                end else begin
                    run0[i]++;
                    run1[i] = 0;
                end
                if (run1[i] >= 3) new_level[i] = 1'b1;
                if (run0[i] >= 3) new_level[i] = 1'b0;
            end
        end

        new_press = m_level & ~m_level_prev;

        if (m_pending && fs) begin
            m_page    = m_target;
            m_pending = 1'b0;
        end else if (!m_pending && m_press[PK]) begin
            m_target  = (m_page + 1) % NP;
            m_pending = 1'b1;
        end

        m_level_prev = m_level;
        m_level      = new_level;
        m_press      = new_press;
        edge_n++;
    endtask

    task automatic check_output();
        logic [15:0] exp_btns;
        exp_btns = m_pending ? 16'd0 : (m_level & ~(16'(1) << PK));
        check_val("btn_level",   kp_if.btn_level,            m_level);
        check_val("btn_press",   kp_if.btn_press,            m_press);
        check_val("page_btns",   kp_if.page_btns,            exp_btns);
        check_val("page_status", {14'd0, kp_if.page_status}, 16'(m_page));
        check_val("switching",   {15'd0, kp_if.switching},   {15'd0, m_pending});
    endtask

    // Called at a falling edge: drive inputs, let one rising edge happen, check at the next falling edge.
    task automatic apply_stimulus(input logic [15:0] raw, input logic fs);
        kp_if.btn_raw     = raw;
        kp_if.frame_start = fs;
        @(posedge vga_clk);
        model_edge(raw, fs);
        @(negedge vga_clk);
        if (kp_if.btn_press[5]) press_cnt5++;
        if (kp_if.btn_level[5]) level5_seen++;
        check_output();
    endtask

    task automatic do_reset();
        vga_rst = 1'b0;
        #1;
        check_val("rst_btn_level",   kp_if.btn_level,            16'd0);
        check_val("rst_btn_press",   kp_if.btn_press,            16'd0);
        check_val("rst_page_btns",   kp_if.page_btns,            16'd0);
        check_val("rst_page_status", {14'd0, kp_if.page_status}, 16'd0);
        check_val("rst_switching",   {15'd0, kp_if.switching},   16'd0);
        kp_if.btn_raw     = '0;
        kp_if.frame_start = 1'b0;
        model_reset();
        repeat (2) @(negedge vga_clk);
        vga_rst = 1'b1;
    endtask

    task automatic idle_cycles(input int n, input logic [15:0] raw);
        for (int i = 0; i < n; i++) apply_stimulus(raw, 1'b0);
    endtask

    task automatic tap_page_key();
        idle_cycles(20, 16'h0001);
        idle_cycles(20, 16'h0000);
    endtask

    initial begin
        logic [15:0] held;
        logic [15:0] raw;
        kp_if.btn_raw     = '0;
        kp_if.frame_start = 1'b0;
        press_cnt5  = 0;
        level5_seen = 0;
        #3;
        do_reset();

        // Held key 5 debounces to a single press pulse.
        press_cnt5 = 0;
        idle_cycles(24, 16'h0020);
        check_val("key5_level_held",  {15'd0, kp_if.btn_level[5]}, 16'd1);
        check_val("key5_pagebtn",     {15'd0, kp_if.page_btns[5]}, 16'd1);
        check_val("key5_press_count", 16'(press_cnt5),             16'd1);
        press_cnt5 = 0;
        idle_cycles(24, 16'h0000);
        check_val("key5_release_level", {15'd0, kp_if.btn_level[5]}, 16'd0);
        check_val("key5_release_press", 16'(press_cnt5),             16'd0);

        // Bounce: toggle every 4 cycles for 40 cycles.
        press_cnt5  = 0;
        level5_seen = 0;
        for (int i = 0; i < 40; i++) apply_stimulus(((i / 4) % 2 == 0) ? 16'h0020 : 16'h0000, 1'b0);
        check_val("bounce_level_seen", 16'(level5_seen), 16'd0);
        check_val("bounce_press_seen", 16'(press_cnt5),  16'd0);
        idle_cycles(16, 16'h0000);

        // Page advance with a long wait before frame_start.
        tap_page_key();
        check_val("adv_switching_wait", {15'd0, kp_if.switching}, 16'd1);
        check_val("adv_page_btns_wait", kp_if.page_btns,          16'd0);
        idle_cycles(60, 16'h0000);
        check_val("adv_page_before", {14'd0, kp_if.page_status}, 16'd0);
        apply_stimulus(16'h0000, 1'b1);
        check_val("adv_page_after",      {14'd0, kp_if.page_status}, 16'd1);
        check_val("adv_switching_after", {15'd0, kp_if.switching},   16'd0);

        // Second advance with an extra press while pending, then a wrap.
        tap_page_key();
        tap_page_key();
        apply_stimulus(16'h0000, 1'b1);
        check_val("adv_page_2", {14'd0, kp_if.page_status}, 16'd2);
        idle_cycles(5, 16'h0000);
        check_val("no_double_adv", {15'd0, kp_if.switching}, 16'd0);
        tap_page_key();
        apply_stimulus(16'h0000, 1'b1);
        check_val("adv_page_wrap", {14'd0, kp_if.page_status}, 16'd0);

        // frame_start coinciding with the press pulse must not complete the switch.
        for (int i = 0; i < 20; i++) apply_stimulus(16'h0001, m_press[PK]);
        check_val("simul_page_same",  {14'd0, kp_if.page_status}, 16'd0);
        check_val("simul_switching",  {15'd0, kp_if.switching},   16'd1);
        idle_cycles(20, 16'h0000);
        apply_stimulus(16'h0000, 1'b1);
        check_val("simul_page_next", {14'd0, kp_if.page_status}, 16'd1);

        // Random key traffic with occasional bounce glitches and frame starts.
        held = '0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 7) == 0) held[$urandom_range(0, 15)] ^= 1'b1;
            raw = held;
            if ($urandom_range(0, 9) == 0) raw = raw ^ (16'(1) << $urandom_range(0, 15));
            apply_stimulus(raw, ($urandom_range(0, 39) == 0));
        end

        // Reset while a switch is pending discards it.
        idle_cycles(24, 16'h0000);
        tap_page_key();
        check_val("mid_pending_switching", {15'd0, kp_if.switching}, 16'd1);
        #2;
        do_reset();
        for (int i = 0; i < 30; i++) apply_stimulus(16'h0000, (i % 10) == 9);
        check_val("post_reset_page",      {14'd0, kp_if.page_status}, 16'd0);
        check_val("post_reset_switching", {15'd0, kp_if.switching},   16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
